// File: rtl/cpu_pkg.sv
// Shared CPU front-end constants: opcodes and the canonical NOP encoding.
package cpu_pkg;

  localparam logic [6:0]  OPC_HALT   = 7'h7F;
  localparam logic [6:0]  OPC_JAL    = 7'h6F;
  localparam logic [6:0]  OPC_BRANCH = 7'h63;
  localparam logic [31:0] INS_NOP    = 32'h0000_0013;

endpackage

// File: rtl/if_id_queue.sv
// Fetch-to-decode queue: buffers {pc, instruction} pairs, drains on flush and
// freezes permanently (until reset) once a halt instruction has been consumed.
module if_id_queue
  import cpu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           pc_in,
  input  logic [31:0]                ins_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_pc,
  output logic [31:0]                out_ins,
  output logic                       out_halt,
  output logic                       halted,
  output logic [$clog2(DEPTH+1)-1:0] level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] LevelFull = LW'(DEPTH);

  logic [WIDTH-1:0] pc_mem  [DEPTH];
  logic [31:0]      ins_mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          halted_q, halted_d;

  logic       push, pop;
  logic [31:0] head_ins;

  // in_ready depends only on local state, rst and flush, never on out_ready.
  assign in_ready  = rst & ~flush & ~halted_q & (level_q < LevelFull);
  assign out_valid = (level_q != '0) & ~halted_q;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  assign head_ins = ins_mem[rd_ptr_q];
  assign out_pc   = out_valid ? pc_mem[rd_ptr_q] : '0;
  assign out_ins  = out_valid ? head_ins : INS_NOP;
  assign out_halt = out_valid & (head_ins[6:0] == OPC_HALT);
  assign halted   = halted_q;
  assign level    = level_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    halted_d = halted_q;
    if (flush) begin
      // A pop in the flush cycle is void, so a queued halt cannot latch here.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
        if (head_ins[6:0] == OPC_HALT) halted_d = 1'b1;
      end
      unique case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      halted_q <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      halted_q <= halted_d;
    end
  end

  // Storage is not reset; push already excludes reset, flush and halt.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]  <= pc_in;
      ins_mem[wr_ptr_q] <= ins_in;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_if_id_queue;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned LW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] pc_in;
  logic [31:0]      ins_in;
  logic             in_valid;
  logic             in_ready;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_pc;
  logic [31:0]      out_ins;
  logic             out_halt;
  logic             halted;
  logic [LW-1:0]    level;

  int tests = 0;
  int fails = 0;

  // Reference model: FIFO contents and the sticky halt flag.
  logic [WIDTH-1:0] m_pc  [$];
  logic [31:0]      m_ins [$];
  logic             m_halted = 1'b0;

  if_id_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_in     (pc_in),
    .ins_in    (ins_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_ins   (out_ins),
    .out_halt  (out_halt),
    .halted    (halted),
    .level     (level)
  );

  always #5 clk = ~clk;

  function automatic logic exp_in_ready();
    return rst && !flush && !m_halted && (m_pc.size() < DEPTH);
  endfunction

  function automatic logic exp_out_valid();
    return (m_pc.size() != 0) && !m_halted;
  endfunction

  function automatic logic [WIDTH-1:0] exp_out_pc();
    return exp_out_valid() ? m_pc[0] : '0;
  endfunction

  function automatic logic [31:0] exp_out_ins();
    return exp_out_valid() ? m_ins[0] : 32'h0000_0013;
  endfunction

  function automatic logic exp_out_halt();
    return exp_out_valid() && (m_ins[0][6:0] == 7'h7F);
  endfunction

  function automatic logic [LW-1:0] exp_level();
    return LW'(m_pc.size());
  endfunction

  function automatic logic [31:0] plain_ins();
    return ($urandom & 32'hFFFF_FF80) | 32'h0000_0013;
  endfunction

  // Called just after a negedge; leaves inputs settled well before the posedge.
  task automatic drive(input logic v, input logic [WIDTH-1:0] pc, input logic [31:0] ins,
                       input logic ordy, input logic fl);
    in_valid  = v;
    pc_in     = pc;
    ins_in    = ins;
    out_ready = ordy;
    flush     = fl;
    #1;
  endtask

  task automatic tick();
    logic m_push, m_pop;
    m_push = in_valid && exp_in_ready();
    m_pop  = exp_out_valid() && out_ready;
    @(posedge clk);
    if (!rst) begin
      m_pc.delete();
      m_ins.delete();
      m_halted = 1'b0;
    end else if (flush) begin
      m_pc.delete();
      m_ins.delete();
    end else begin
      if (m_pop) begin
        if (m_ins[0][6:0] == 7'h7F) m_halted = 1'b1;
        void'(m_pc.pop_front());
        void'(m_ins.pop_front());
      end
      if (m_push) begin
        m_pc.push_back(pc_in);
        m_ins.push_back(ins_in);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    drive(1'b1, 32'h100, 32'h13, 1'b1, 1'b0);
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL reset_in_ready_low: got %b want 0", in_ready);
    end
    tick();
    tick();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tests++;
    if ({in_ready, out_valid, halted, out_halt} !== 4'b1000) begin
      fails++; $display("FAIL reset_flags: got %b want 1000", {in_ready, out_valid, halted, out_halt});
    end
    tests++;
    if (level !== '0 || out_pc !== '0 || out_ins !== 32'h13) begin
      fails++; $display("FAIL reset_outputs: got level=%0d pc=%h ins=%h want 0/0/00000013",
                        level, out_pc, out_ins);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4), plain_ins(), 1'b0, 1'b0);
      tests++;
      if (in_ready !== 1'b1) begin
        fails++; $display("FAIL fill_in_ready_%0d: got %b want 1", i, in_ready);
      end
      tick();
    end
    drive(1'b1, 32'h10, plain_ins(), 1'b0, 1'b0);
    tests++;
    if (level !== 3'd4 || in_ready !== 1'b0) begin
      fails++; $display("FAIL fill_full: got level=%0d in_ready=%b want 4/0", level, in_ready);
    end
    tick();
    tests++;
    if (level !== 3'd4 || out_pc !== 32'h0) begin
      fails++; $display("FAIL fill_reject: got level=%0d head=%h want 4/0", level, out_pc);
    end
  endtask

  task automatic test_full_pop();
    drive(1'b1, 32'h10, plain_ins(), 1'b1, 1'b0);
    tests++;
    if (out_pc !== 32'h0 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
      fails++; $display("FAIL fullpop_head: got pc=%h ov=%b ir=%b want 0/1/0",
                        out_pc, out_valid, in_ready);
    end
    tick();
    tests++;
    if (level !== 3'd3 || out_pc !== 32'h4) begin
      fails++; $display("FAIL fullpop_level: got level=%0d head=%h want 3/4", level, out_pc);
    end
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, '0, '0, 1'b1, 1'b0);
      tests++;
      if (out_pc !== 32'(4 + 4 * k) || out_ins !== exp_out_ins()) begin
        fails++; $display("FAIL fullpop_drain_%0d: got pc=%h ins=%h want %h/%h", k, out_pc,
                          out_ins, 32'(4 + 4 * k), exp_out_ins());
      end
      tick();
    end
    tests++;
    if (level !== '0 || out_valid !== 1'b0) begin
      fails++; $display("FAIL fullpop_empty: got level=%0d ov=%b want 0/0", level, out_valid);
    end
  endtask

  task automatic test_wrap();
    int next_push = 0;
    int next_pop  = 0;
    int guard     = 0;
    while (next_pop < 6 && guard < 40) begin
      logic v, r;
      v = (next_push < 6);
      r = (next_push >= 2);
      drive(v, 32'(next_push * 4), plain_ins(), r, 1'b0);
      if (out_valid && r) begin
        tests++;
        if (out_pc !== 32'(next_pop * 4)) begin
          fails++; $display("FAIL wrap_order_%0d: got %h want %h", next_pop, out_pc,
                            32'(next_pop * 4));
        end
        next_pop++;
      end
      if (v && in_ready) next_push++;
      tick();
      guard++;
    end
    tests++;
    if (next_pop != 6 || level !== '0) begin
      fails++; $display("FAIL wrap_done: got pops=%0d level=%0d want 6/0", next_pop, level);
    end
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h30, plain_ins(), 1'b0, 1'b0); tick();
    drive(1'b1, 32'h34, plain_ins(), 1'b0, 1'b0); tick();
    drive(1'b1, 32'h38, plain_ins(), 1'b1, 1'b1);
    tests++;
    if (in_ready !== 1'b0) begin
      fails++; $display("FAIL flush_in_ready: got %b want 0", in_ready);
    end
    tick();
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tests++;
    if (level !== '0 || out_valid !== 1'b0 || out_ins !== 32'h13 || out_pc !== '0) begin
      fails++; $display("FAIL flush_empty: got level=%0d ov=%b ins=%h pc=%h want 0/0/13/0",
                        level, out_valid, out_ins, out_pc);
    end
  endtask

  task automatic test_halt();
    drive(1'b1, 32'h8, 32'h0000_007F, 1'b0, 1'b0); tick();
    drive(1'b1, 32'hC, 32'h13, 1'b1, 1'b0);
    tests++;
    if (out_halt !== 1'b1 || out_pc !== 32'h8 || halted !== 1'b0) begin
      fails++; $display("FAIL halt_head: got oh=%b pc=%h halted=%b want 1/8/0",
                        out_halt, out_pc, halted);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h50, 32'h13, 1'b1, k == 1);
      tests++;
      if ({halted, in_ready, out_valid, out_halt} !== 4'b1000 || out_ins !== 32'h13) begin
        fails++; $display("FAIL halt_frozen_%0d: got h/ir/ov/oh=%b ins=%h want 1000/13", k,
                          {halted, in_ready, out_valid, out_halt}, out_ins);
      end
      tick();
    end
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tick();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, 1'b0);
    tests++;
    if (halted !== 1'b0 || in_ready !== 1'b1 || level !== '0) begin
      fails++; $display("FAIL halt_reset: got halted=%b ir=%b level=%0d want 0/1/0",
                        halted, in_ready, level);
    end
  endtask

  task automatic test_halt_flush();
    drive(1'b1, 32'h18, 32'h0000_007F, 1'b0, 1'b0); tick();
    drive(1'b0, '0, '0, 1'b1, 1'b1); tick();
    drive(1'b1, 32'h20, 32'h0000_0093, 1'b0, 1'b0);
    tests++;
    if (halted !== 1'b0 || level !== '0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL haltflush_state: got halted=%b level=%0d ir=%b want 0/0/1",
                        halted, level, in_ready);
    end
    tick();
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    tests++;
    if (out_pc !== 32'h20 || out_ins !== 32'h93 || out_halt !== 1'b0) begin
      fails++; $display("FAIL haltflush_push: got pc=%h ins=%h oh=%b want 20/93/0",
                        out_pc, out_ins, out_halt);
    end
    tick();
    tests++;
    if (level !== '0 || halted !== 1'b0) begin
      fails++; $display("FAIL haltflush_pop: got level=%0d halted=%b want 0/0", level, halted);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      logic [31:0] ins;
      rst = ($urandom_range(0, 99) >= 2);
      ins = ($urandom_range(0, 99) < 3) ? (plain_ins() | 32'h7F) : plain_ins();
      drive($urandom_range(0, 99) < 65, $urandom, ins, $urandom_range(0, 99) < 55,
            $urandom_range(0, 99) < 6);
      tests++;
      if ({in_ready, out_valid, out_halt, halted, level, out_pc, out_ins} !==
          {exp_in_ready(), exp_out_valid(), exp_out_halt(), m_halted, exp_level(),
           exp_out_pc(), exp_out_ins()}) begin
        fails++;
        $display("FAIL random_%0d: got ir=%b ov=%b oh=%b h=%b lv=%0d pc=%h ins=%h want ir=%b ov=%b oh=%b h=%b lv=%0d pc=%h ins=%h",
                 n, in_ready, out_valid, out_halt, halted, level, out_pc, out_ins,
                 exp_in_ready(), exp_out_valid(), exp_out_halt(), m_halted, exp_level(),
                 exp_out_pc(), exp_out_ins());
      end
      tick();
    end
    rst = 1'b1;
  endtask

  initial begin
    rst       = 1'b0;
    in_valid  = 1'b0;
    pc_in     = '0;
    ins_in    = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    @(negedge clk);
    test_reset();
    test_fill();
    test_full_pop();
    test_wrap();
    test_flush();
    test_halt();
    test_halt_flush();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
